// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and the byte-merge helper for the register file
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} clear_state_t;
  localparam int MAX_W = 1024;
  function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0] old_word,
                                                   input logic [MAX_W-1:0] new_word,
                                                   input logic [MAX_W/8-1:0] strobe);
    logic [MAX_W-1:0] r;
    r = old_word;
    for (int b = 0; b < MAX_W / 8; b++) if (strobe[b]) r[8*b+:8] = new_word[8*b+:8];
    return r;
  endfunction
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: bulk-clear sweep FSM, busy flag and dropped-write counter
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_enable,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic [7:0]       dropped_writes,
  output logic [IDX_W-1:0] sweep_index,
  output logic             sweep_we
);
  clear_state_t state;
  logic [IDX_W-1:0] count;
  assign clear_busy = state == CLEAR;
  assign sweep_we = clear_busy;
  assign sweep_index = count;
  // sweep one entry per edge; writes arriving mid-sweep are counted and discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      dropped_writes <= '0;
    end else begin
      if (state == IDLE) begin
        if (clear_req) begin
          state <= CLEAR;
          count <= '0;
        end
      end else begin
        count <= count + 1'b1;
        if (count == IDX_W'(DEPTH - 1)) state <= IDLE;
      end
      if (state == CLEAR && write_enable && dropped_writes != 8'hFF)
        dropped_writes <= dropped_writes + 8'd1;
    end
  end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised 1W/2R register file with byte strobes, bypass and bulk clear
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS = 1'b1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_enable,
  input  logic [IDX_W-1:0]        write_index,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  input  logic [IDX_W-1:0]        read_a_index,
  output logic [DATA_WIDTH-1:0]   read_a_data,
  input  logic [IDX_W-1:0]        read_b_index,
  output logic [DATA_WIDTH-1:0]   read_b_data,
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic [7:0]              dropped_writes
);
  logic [DATA_WIDTH-1:0] storage [DEPTH];
  logic [DATA_WIDTH-1:0] merged;
  logic [IDX_W-1:0] sweep_index;
  logic sweep_we, wr_hit;
  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear (
    .clk(clk),
    .rst_n(rst_n),
    .write_enable(write_enable),
    .clear_req(clear_req),
    .clear_busy(clear_busy),
    .dropped_writes(dropped_writes),
    .sweep_index(sweep_index),
    .sweep_we(sweep_we)
  );
  // merged word serves both the write path and the same-cycle bypass
  always_comb begin
    wr_hit = write_enable && !clear_busy && !(ZERO_REG && write_index == '0);
    merged = DATA_WIDTH'(merge_bytes(MAX_W'(storage[write_index]), MAX_W'(write_data),
                                     (MAX_W/8)'(write_strobe)));
    read_a_data = (ZERO_REG && read_a_index == '0) ? '0 :
                  (BYPASS && wr_hit && read_a_index == write_index) ? merged : storage[read_a_index];
    read_b_data = (ZERO_REG && read_b_index == '0) ? '0 :
                  (BYPASS && wr_hit && read_b_index == write_index) ? merged : storage[read_b_index];
  end
  // sweep zeroing has priority; accepted writes store the strobe-merged word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (sweep_we) begin
      storage[sweep_index] <= '0;
    end else if (wr_hit) begin
      storage[write_index] <= merged;
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: three configurations checked against a behavioural register-file model
module tb_regfile_param;
  logic clk = 0, rst_n = 1, we = 0, clr = 0;
  logic [2:0] widx = 0, ra_idx = 0, rb_idx = 0;
  logic [31:0] wdata = 0;
  logic [3:0] stb = 0;
  logic [31:0] ra [3], rb [3];
  logic busy [3];
  logic [7:0] drop [3];
  int checks = 0, errors = 0;
  logic [31:0] m [3][8];
  int dep [3] = '{4, 4, 8};
  bit zr [3] = '{0, 1, 0};
  bit bp [3] = '{1, 0, 1};
  bit mb [3];
  int mp [3], md [3];

  typedef struct {
    bit we;
    logic [2:0] idx;
    logic [31:0] data;
    logic [3:0] stb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  regfile_param #(.DATA_WIDTH(32), .DEPTH(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_index(widx[1:0]), .write_data(wdata),
    .write_strobe(stb), .read_a_index(ra_idx[1:0]), .read_a_data(ra[0]), .read_b_index(rb_idx[1:0]),
    .read_b_data(rb[0]), .clear_req(clr), .clear_busy(busy[0]), .dropped_writes(drop[0]));
  regfile_param #(.DATA_WIDTH(32), .DEPTH(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_index(widx[1:0]), .write_data(wdata),
    .write_strobe(stb), .read_a_index(ra_idx[1:0]), .read_a_data(ra[1]), .read_b_index(rb_idx[1:0]),
    .read_b_data(rb[1]), .clear_req(clr), .clear_busy(busy[1]), .dropped_writes(drop[1]));
  regfile_param #(.DATA_WIDTH(32), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .write_enable(we), .write_index(widx), .write_data(wdata),
    .write_strobe(stb), .read_a_index(ra_idx), .read_a_data(ra[2]), .read_b_index(rb_idx),
    .read_b_data(rb[2]), .clear_req(clr), .clear_busy(busy[2]), .dropped_writes(drop[2]));

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b+:8] = s[b] ? n[8*b+:8] : o[8*b+:8];
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input int d, input logic [2:0] idx);
    int i, w;
    i = int'(idx) % dep[d];
    w = int'(widx) % dep[d];
    if (zr[d] && i == 0) return 0;
    if (bp[d] && !mb[d] && we && w == i) return merge(m[d][i], wdata, stb);
    return m[d][i];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) m[d][i] = 0;
      mb[d] = 0; mp[d] = 0; md[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (mb[d]) begin
        m[d][mp[d]] = 0;
        if (we) md[d] = md[d] < 255 ? md[d] + 1 : 255;
        mp[d]++;
        if (mp[d] == dep[d]) mb[d] = 0;
      end else begin
        int w;
        w = int'(widx) % dep[d];
        if (we && !(zr[d] && w == 0)) m[d][w] = merge(m[d][w], wdata, stb);
        if (clr) begin mb[d] = 1; mp[d] = 0; end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("u%0d_read_a[%0d]", d, ra_idx), ra[d], exp_read(d, ra_idx));
      chk($sformatf("u%0d_read_b[%0d]", d, rb_idx), rb[d], exp_read(d, rb_idx));
      chk($sformatf("u%0d_busy", d), {31'b0, busy[d]}, {31'b0, mb[d]});
      chk($sformatf("u%0d_dropped", d), {24'b0, drop[d]}, md[d]);
    end
  endtask

  task automatic check_entries();
    for (int i = 0; i < 8; i++) begin
      ra_idx = 3'(i);
      rb_idx = 3'(7 - i);
      #1;
      check_all();
    end
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      we = 1; widx = 3'(i); wdata = i + 1; stb = 4'hF;
      cycle();
    end
    we = 0;
  endtask

  initial begin
    int n;
    vecs[0] = '{1, 3'd0, 32'd0, 4'hF, 32'd0};
    vecs[1] = '{1, 3'd1, 32'd1, 4'hF, 32'd1};
    vecs[2] = '{1, 3'd2, 32'd2, 4'hF, 32'd2};
    vecs[3] = '{1, 3'd3, 32'd3, 4'hF, 32'd3};
    vecs[4] = '{1, 3'd2, 32'h11223344, 4'hF, 32'h11223344};
    vecs[5] = '{1, 3'd2, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    vecs[6] = '{1, 3'd1, 32'd5, 4'hF, 32'd5};
    vecs[7] = '{0, 3'd1, 32'd7, 4'hF, 32'd5};
    model_reset();
    #1 rst_n = 0;
    #20;
    check_entries();
    @(negedge clk) rst_n = 1;
    for (int v = 0; v < 8; v++) begin
      we = vecs[v].we; widx = vecs[v].idx; wdata = vecs[v].data; stb = vecs[v].stb;
      ra_idx = vecs[v].idx; rb_idx = vecs[v].idx;
      #1 check_all();
      cycle();
      we = 0;
      #1;
      chk($sformatf("vec%0d_a", v), ra[0], vecs[v].exp);
      chk($sformatf("vec%0d_b", v), rb[0], vecs[v].exp);
      check_all();
    end
    we = 1; widx = 1; wdata = 5; stb = 4'hF; ra_idx = 1;
    cycle();
    wdata = 9;
    #1;
    chk("bypass_on_pre", ra[0], 32'd9);
    chk("bypass_off_pre", ra[1], 32'd5);
    cycle();
    we = 0;
    #1;
    chk("bypass_on_post", ra[0], 32'd9);
    chk("bypass_off_post", ra[1], 32'd9);
    we = 1; widx = 0; wdata = 32'hFFFF_FFFF; stb = 4'hF; ra_idx = 0; rb_idx = 0;
    #1 chk("zero_pre", ra[1], 32'd0);
    cycle();
    we = 0;
    #1;
    chk("zero_a", ra[1], 32'd0);
    chk("zero_b", rb[1], 32'd0);
    chk("zero_dropped", {24'b0, drop[1]}, 32'd0);
    check_all();
    fill();
    check_entries();
    clr = 1;
    cycle();
    clr = 0;
    n = 0;
    while (busy[2] && n < 20) begin
      we = n >= 1 && n <= 3; widx = 3'(n); wdata = 32'hDEAD_0000 + n; stb = 4'hF;
      cycle();
      ra_idx = 3'(n); rb_idx = 3'(n + 1);
      #1;
      chk($sformatf("swept_%0d", n), ra[2], 32'd0);
      chk($sformatf("unswept_%0d", n + 1), rb[2], n < 7 ? n + 2 : 0);
      check_all();
      n++;
    end
    we = 0;
    chk("busy_cycles", n, 32'd8);
    chk("clear_dropped", {24'b0, drop[2]}, 32'd3);
    we = 1; widx = 5; wdata = 32'hCAFE_BABE; stb = 4'hF;
    cycle();
    we = 0; ra_idx = 5;
    #1 chk("post_clear_write", ra[2], 32'hCAFE_BABE);
    check_all();
    fill();
    clr = 1;
    cycle();
    clr = 0;
    cycle();
    cycle();
    #2 rst_n = 0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy_u%0d", d), {31'b0, busy[d]}, 32'd0);
      chk($sformatf("rst_dropped_u%0d", d), {24'b0, drop[d]}, 32'd0);
    end
    check_entries();
    @(negedge clk) rst_n = 1;
    we = 1; widx = 3; wdata = 32'h1234_5678; stb = 4'hF;
    cycle();
    we = 0; ra_idx = 3;
    #1 chk("post_reset_write", ra[2], 32'h1234_5678);
    for (int t = 0; t < 300; t++) begin
      we = $urandom_range(0, 1) == 1;
      widx = 3'($urandom_range(0, 7));
      wdata = $urandom;
      stb = 4'($urandom_range(0, 15));
      ra_idx = 3'($urandom_range(0, 7));
      rb_idx = $urandom_range(0, 3) == 0 ? widx : 3'($urandom_range(0, 7));
      clr = $urandom_range(0, 19) == 0;
      #1 check_all();
      cycle();
      check_all();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-ported register file: the next generation of the fixed 4×32 register file in the datapath, with width and depth set per instance. Provides one write port with byte strobes, two combinational read ports, optional write-to-read bypass, an optional hard-wired zero register, and a sequenced bulk-clear operation with a busy handshake. Sits between the decode stage (read indices) and the writeback stage (write port).

## Interface

- DATA_WIDTH, 32: word width in bits; multiple of 8, ≥8.
- DEPTH, 4: number of entries; power of two, ≥2; IDX_W = $clog2(DEPTH).
- ZERO_REG, 0: 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- write_enable  in  1  write request this cycle.
- write_index  in  IDX_W  target entry.
- write_data  in  DATA_WIDTH  write word.
- write_strobe  in  DATA_WIDTH/8  byte enables; bit b covers bits [8b+7:8b].
- read_a_index  in  IDX_W  port A entry select.
- read_a_data  out  DATA_WIDTH  port A data, combinational.
- read_b_index  in  IDX_W  port B entry select.
- read_b_data  out  DATA_WIDTH  port B data, combinational.
- clear_req  in  1  start bulk clear; sampled on the rising edge.
- clear_busy  out  1  bulk clear in progress.
- dropped_writes  out  8  saturating count of writes discarded during a clear.

## Operation

- Write: when write_enable and not clear_busy, the bytes selected by write_strobe in entry write_index take write_data bytes on the rising edge; unselected bytes hold. Strobe 0 is a legal no-op.
- ZERO_REG=1: writes to index 0 are discarded (not counted as dropped); both ports read 0 at index 0.
- Reads: read_x_data = storage[read_x_index], purely combinational, both ports independent, A and B may select the same entry.
- Bypass (BYPASS=1, not clear_busy, write_enable, indices equal, index not suppressed by ZERO_REG): read data = storage word with strobed bytes replaced by write_data. BYPASS=0: reads show the old value until after the edge.
- Clear FSM states: IDLE, CLEAR.
  - IDLE → CLEAR on clear_req; sweep counter loads 0.
  - CLEAR: each edge zeroes entry counter, then counter+1; after zeroing entry DEPTH-1 → IDLE.
  - clear_req in CLEAR is ignored (no restart, no queueing).
  - clear_busy = (state == CLEAR).
- Writes during CLEAR are discarded; each discarded write_enable cycle increments dropped_writes, saturating at 255. dropped_writes clears only on reset.
- Reads during CLEAR return current storage: entries already swept read 0, others their old value; bypass is off.
- Simultaneous write_enable and clear_req in IDLE: the write is performed on that edge, and the clear then sweeps and zeroes it.

## Timing

- Reset (rst_n low, asynchronous): all entries 0, state IDLE, counter 0, clear_busy 0, dropped_writes 0. Read outputs therefore show 0 during reset.
- Reset asserted mid-clear aborts the sweep immediately. All state returns to reset values; no partial-sweep residue.
- Write latency: data is visible on the read ports immediately after the capturing edge (or in the same cycle with BYPASS).
- Clear latency: clear_req sampled at edge k.
  - clear_busy is high after edge k until edge k+DEPTH.
  - Entry i is zeroed at edge k+1+i.
  - The first accepted write is at edge k+DEPTH+1 or later.
- Counter is IDX_W bits. The DEPTH-1 compare ends the sweep with no wrap into entry 0.

## Structure

- Package regfile_pkg: state enum typedef (IDLE, CLEAR), and a function merge_bytes(old, new, strobe) used by both the write path and the bypass path.
- Sub-module regfile_clear_seq: FSM, sweep counter, clear_busy and the dropped_writes counter. It exports a sweep index and sweep-write enable to the storage array in the top level.

## Test plan

- DEPTH=4, DATA_WIDTH=32: write value i to entry i for i=0..3, strobe 4'hF.
  - Required: A and B both read 0,1,2,3 at every index.
- Byte strobe: entry 2 = 32'h11223344, then write 32'hAABBCCDD with strobe 4'b0101.
  - Required: entry 2 reads 32'h11BB33DD.
- Bypass:
  - BYPASS=1: entry 1 = 5; in the same cycle write 9 to entry 1 with read_a_index=1. Required: read_a_data=9 before the edge.
  - BYPASS=0: same stimulus. Required: read_a_data=5 before the edge and 9 after it.
- ZERO_REG=1: write 32'hFFFF_FFFF to index 0.
  - Required: reads 0 on both ports; dropped_writes stays 0.
- Clear, DEPTH=8: fill entries with 1..8, pulse clear_req, hold write_enable high for 3 cycles during the sweep.
  - Required: clear_busy high for exactly 8 cycles; entries zero in index order; dropped_writes=3.
  - Required: a write on the first cycle after busy falls is stored.
- Reset mid-clear: assert rst_n=0 with the sweep at entry 2.
  - Required: clear_busy=0 immediately, all reads 0, dropped_writes=0.
  - Required: after release, normal writes work.
